bsg_manycore_host_request_responder: RTL

- Synthesizable host-side responder for manycore requests addressed to the host/IO coordinate. Tiles send these requests for finish, fail, time, stdout/stderr and print-stat.
- Decodes each request by EPA and returns a response on the return network.
- Forwards decoded host events through an event FIFO to the host-side consumer: the DPI host endpoint or a post-synth monitor.
- Replaces ad-hoc snooping of the host link.

---
 rtl/bsg_manycore_host_responder_pkg.sv | 64 ++++++
 rtl/bsg_fifo_1r1w_small.sv | 58 +++++
 rtl/bsg_manycore_host_epa_decode.sv | 71 +++++++
 rtl/bsg_manycore_host_request_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_host_responder_pkg.sv
// Shared definitions for the manycore host request responder.
// Holds the host EPA map, host event codes, response types, the packed
// response/event FIFO entry layouts and a small payload helper.
// The entry structs are sized by the *_lp widths below. The top-level
// width parameters default to these values and must stay equal to them.
package bsg_manycore_host_responder_pkg;

  localparam int host_addr_width_lp   = 28;
  localparam int host_data_width_lp   = 32;
  localparam int host_x_width_lp      = 7;
  localparam int host_y_width_lp      = 7;
  localparam int host_reg_id_width_lp = 5;

  // Word EPAs of the host-mapped registers.
  localparam logic [15:0] epa_finish_lp     = 16'h3AB4;
  localparam logic [15:0] epa_time_lp       = 16'h3AB5;
  localparam logic [15:0] epa_fail_lp       = 16'h3AB6;
  localparam logic [15:0] epa_stdout_lp     = 16'h3AB7;
  localparam logic [15:0] epa_stderr_lp     = 16'h3AB8;
  localparam logic [15:0] epa_print_stat_lp = 16'h3AB9;

  // Request opcodes. Any other value is an amo, which the host does not support.
  localparam logic [1:0] op_load_lp  = 2'd0;
  localparam logic [1:0] op_store_lp = 2'd1;

  typedef enum logic [2:0] {
    HOST_EVT_FINISH     = 3'd0,
    HOST_EVT_TIME       = 3'd1,
    HOST_EVT_FAIL       = 3'd2,
    HOST_EVT_STDOUT     = 3'd3,
    HOST_EVT_STDERR     = 3'd4,
    HOST_EVT_PRINT_STAT = 3'd5,
    HOST_EVT_RSVD6      = 3'd6,
    HOST_EVT_ERROR      = 3'd7
  } host_event_e;

  typedef enum logic {
    RSP_LOAD_DATA = 1'b0,
    RSP_STORE_ACK = 1'b1
  } rsp_type_e;

  typedef struct packed {
    rsp_type_e                       typ;
    logic [host_data_width_lp-1:0]   data;
    logic [host_x_width_lp-1:0]      x;
    logic [host_y_width_lp-1:0]      y;
    logic [host_reg_id_width_lp-1:0] reg_id;
  } rsp_entry_s;

  typedef struct packed {
    host_event_e                   typ;
    logic [host_data_width_lp-1:0] data;
    logic [host_x_width_lp-1:0]    x;
    logic [host_y_width_lp-1:0]    y;
  } evt_entry_s;

  // Character payloads carry only the low byte of the store data.
  function automatic logic [host_data_width_lp-1:0] char_payload(
    input logic [host_data_width_lp-1:0] d
  );
    return {{(host_data_width_lp-8){1'b0}}, d[7:0]};
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with valid/ready input and valid/yumi output.
// Ports: clk_i, reset_i (sync, active-high); v_i/ready_o/data_i enqueue side;
// v_o/data_o/yumi_i dequeue side. els_p must be a power of two.
// An enqueue while full is accepted when a dequeue happens in the same cycle.
// The caller decides when that is legal.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r;
  logic [ptr_w_lp-1:0] rptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                enq_s;
  logic                deq_s;

  assign v_o     = (cnt_r != '0);
  assign ready_o = (cnt_r != cnt_w_lp'(els_p));
  assign data_o  = mem_r[rptr_r];
  assign deq_s   = yumi_i & v_o;
  assign enq_s   = v_i & (ready_o | deq_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq_s) wptr_r <= wptr_r + ptr_w_lp'(1);
      if (deq_s) rptr_r <= rptr_r + ptr_w_lp'(1);
      case ({enq_s, deq_s})
        2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage write; contents are don't-care until marked valid by cnt_r.
  always_ff @(posedge clk_i) begin
    if (enq_s) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_host_epa_decode.sv
// Combinational decode of a host-bound request by opcode and word EPA.
// Inputs: op (0 load, 1 store, 2/3 amo), addr (word EPA).
// Outputs: evt_needed (request produces a host event), evt_type,
// rsp_type (load data vs store ack), is_time (load of the TIME register),
// unmapped (EPA is not one of the host registers).
module bsg_manycore_host_epa_decode
  import bsg_manycore_host_responder_pkg::*;
#(
  parameter int addr_width_p = host_addr_width_lp
) (
  input  logic [1:0]              op,
  input  logic [addr_width_p-1:0] addr,
  output logic                    evt_needed,
  output host_event_e             evt_type,
  output rsp_type_e               rsp_type,
  output logic                    is_time,
  output logic                    unmapped
);

  logic        mapped_s;
  host_event_e mapped_evt_s;

  // EPA match against the host register map.
  always_comb begin
    mapped_s     = 1'b1;
    mapped_evt_s = HOST_EVT_ERROR;
    case (addr)
      addr_width_p'(epa_finish_lp):     mapped_evt_s = HOST_EVT_FINISH;
      addr_width_p'(epa_time_lp):       mapped_evt_s = HOST_EVT_TIME;
      addr_width_p'(epa_fail_lp):       mapped_evt_s = HOST_EVT_FAIL;
      addr_width_p'(epa_stdout_lp):     mapped_evt_s = HOST_EVT_STDOUT;
      addr_width_p'(epa_stderr_lp):     mapped_evt_s = HOST_EVT_STDERR;
      addr_width_p'(epa_print_stat_lp): mapped_evt_s = HOST_EVT_PRINT_STAT;
      default: begin
        mapped_s     = 1'b0;
        mapped_evt_s = HOST_EVT_ERROR;
      end
    endcase
  end

  // Opcode qualification: loads only raise an event when unmapped; amos always
  // report an error and are acknowledged like stores.
  always_comb begin
    evt_needed = 1'b0;
    evt_type   = HOST_EVT_ERROR;
    rsp_type   = RSP_STORE_ACK;
    is_time    = 1'b0;
    unmapped   = ~mapped_s;
    case (op)
      op_load_lp: begin
        rsp_type   = RSP_LOAD_DATA;
        is_time    = mapped_s & (mapped_evt_s == HOST_EVT_TIME);
        evt_needed = ~mapped_s;
        evt_type   = HOST_EVT_ERROR;
      end
      op_store_lp: begin
        evt_needed = 1'b1;
        if (mapped_s) begin
          evt_type = mapped_evt_s;
        end else begin
          evt_type = HOST_EVT_ERROR;
        end
      end
      default: begin
        evt_needed = 1'b1;
        evt_type   = HOST_EVT_ERROR;
      end
    endcase
  end

endmodule

// File: rtl/bsg_manycore_host_request_responder.sv
// Host-side responder for manycore requests addressed to the host coordinate.
// Decodes each request by EPA, queues a response (2-entry FIFO) for the
// return network and a host event (event_fifo_els_p-deep FIFO) for the host
// consumer, and tracks finish/fail/error status.
// Ports: req_* request in (req_yumi_o combinational accept); rsp_* response
// out, valid/ready; evt_* host events out, valid/yumi; cycle_ctr_i time
// source; done_o/fail_o/error_o status. Reset is synchronous, active-high.
module bsg_manycore_host_request_responder
  import bsg_manycore_host_responder_pkg::*;
#(
  parameter int addr_width_p     = host_addr_width_lp,
  parameter int data_width_p     = host_data_width_lp,
  parameter int x_cord_width_p   = host_x_width_lp,
  parameter int y_cord_width_p   = host_y_width_lp,
  parameter int reg_id_width_p   = host_reg_id_width_lp,
  parameter int event_fifo_els_p = 8,
  parameter int num_finish_p     = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      req_v_i,
  input  logic [1:0]                req_op_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  input  logic [reg_id_width_p-1:0] req_reg_id_i,
  output logic                      req_yumi_o,
  output logic                      rsp_v_o,
  output logic                      rsp_type_o,
  output logic [data_width_p-1:0]   rsp_data_o,
  output logic [x_cord_width_p-1:0] rsp_dst_x_o,
  output logic [y_cord_width_p-1:0] rsp_dst_y_o,
  output logic [reg_id_width_p-1:0] rsp_reg_id_o,
  input  logic                      rsp_ready_i,
  output logic                      evt_v_o,
  output logic [2:0]                evt_type_o,
  output logic [data_width_p-1:0]   evt_data_o,
  output logic [x_cord_width_p-1:0] evt_src_x_o,
  output logic [y_cord_width_p-1:0] evt_src_y_o,
  input  logic                      evt_yumi_i,
  input  logic [63:0]               cycle_ctr_i,
  output logic                      done_o,
  output logic                      fail_o,
  output logic                      error_o
);

  localparam int fc_width_lp = (num_finish_p > 0) ? $clog2(num_finish_p + 1) : 1;
  localparam logic [fc_width_lp-1:0] fc_target_lp = fc_width_lp'(num_finish_p);

  logic        evt_needed_s;
  host_event_e evt_type_s;
  rsp_type_e   rsp_type_s;
  logic        is_time_s;
  logic        unmapped_s;

  logic        accept_s;
  logic        rsp_ready_s;
  logic        rsp_v_s;
  logic        rsp_space_s;
  logic        evt_ready_s;
  logic        evt_v_s;
  logic        evt_space_s;
  logic        evt_enq_s;
  rsp_entry_s  rsp_in_s;
  rsp_entry_s  rsp_out_s;
  evt_entry_s  evt_in_s;
  evt_entry_s  evt_out_s;

  logic [fc_width_lp-1:0] finish_cnt_r;
  logic [fc_width_lp-1:0] finish_cnt_next_s;
  logic                   finish_set_s;
  logic                   fail_set_s;
  logic                   error_set_s;
  logic                   done_r;
  logic                   fail_r;
  logic                   error_r;
  logic                   unused_ctr_hi_s;

  // Only the low word of the cycle counter is visible to tiles.
  assign unused_ctr_hi_s = ^cycle_ctr_i[63:32];

  bsg_manycore_host_epa_decode #(
    .addr_width_p(addr_width_p)
  ) decode (
    .op        (req_op_i),
    .addr      (req_addr_i),
    .evt_needed(evt_needed_s),
    .evt_type  (evt_type_s),
    .rsp_type  (rsp_type_s),
    .is_time   (is_time_s),
    .unmapped  (unmapped_s)
  );

  // A slot is available if the FIFO has room or its head leaves this cycle,
  // which keeps full FIFOs streaming without a bubble.
  assign rsp_space_s = rsp_ready_s | (rsp_v_s & rsp_ready_i);
  assign evt_space_s = evt_ready_s | (evt_v_s & evt_yumi_i);

  // Request acceptance; never during reset so a pending request is dropped.
  always_comb begin
    accept_s = 1'b0;
    if (reset_i) begin
      accept_s = 1'b0;
    end else if (req_v_i & rsp_space_s) begin
      if (evt_needed_s) begin
        accept_s = evt_space_s;
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  assign req_yumi_o = accept_s;
  assign evt_enq_s  = accept_s & evt_needed_s;

  // Response entry; load data is captured at accept time.
  always_comb begin
    rsp_in_s        = '0;
    rsp_in_s.typ    = rsp_type_s;
    rsp_in_s.x      = req_src_x_i;
    rsp_in_s.y      = req_src_y_i;
    rsp_in_s.reg_id = req_reg_id_i;
    if ((rsp_type_s == RSP_LOAD_DATA) && is_time_s) begin
      rsp_in_s.data = data_width_p'(cycle_ctr_i[31:0]);
    end else begin
      rsp_in_s.data = '0;
    end
  end

  // Event entry and payload selection by event code.
  always_comb begin
    evt_in_s     = '0;
    evt_in_s.typ = evt_type_s;
    evt_in_s.x   = req_src_x_i;
    evt_in_s.y   = req_src_y_i;
    case (evt_type_s)
      HOST_EVT_STDOUT, HOST_EVT_STDERR: evt_in_s.data = char_payload(req_data_i);
      HOST_EVT_ERROR:                   evt_in_s.data = data_width_p'(req_addr_i);
      default:                          evt_in_s.data = req_data_i;
    endcase
  end

  bsg_fifo_1r1w_small #(
    .width_p($bits(rsp_entry_s)),
    .els_p  (2)
  ) rsp_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (accept_s),
    .ready_o(rsp_ready_s),
    .data_i (rsp_in_s),
    .v_o    (rsp_v_s),
    .data_o (rsp_out_s),
    .yumi_i (rsp_v_s & rsp_ready_i)
  );

  bsg_fifo_1r1w_small #(
    .width_p($bits(evt_entry_s)),
    .els_p  (event_fifo_els_p)
  ) evt_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (evt_enq_s),
    .ready_o(evt_ready_s),
    .data_i (evt_in_s),
    .v_o    (evt_v_s),
    .data_o (evt_out_s),
    .yumi_i (evt_yumi_i)
  );

  // Drive response/event fields only while valid so idle outputs read as zero.
  always_comb begin
    rsp_v_o      = rsp_v_s;
    rsp_type_o   = 1'b0;
    rsp_data_o   = '0;
    rsp_dst_x_o  = '0;
    rsp_dst_y_o  = '0;
    rsp_reg_id_o = '0;
    evt_v_o      = evt_v_s;
    evt_type_o   = 3'd0;
    evt_data_o   = '0;
    evt_src_x_o  = '0;
    evt_src_y_o  = '0;
    if (rsp_v_s) begin
      rsp_type_o   = rsp_out_s.typ;
      rsp_data_o   = rsp_out_s.data;
      rsp_dst_x_o  = rsp_out_s.x;
      rsp_dst_y_o  = rsp_out_s.y;
      rsp_reg_id_o = rsp_out_s.reg_id;
    end else begin
      rsp_type_o   = 1'b0;
    end
    if (evt_v_s) begin
      evt_type_o  = evt_out_s.typ;
      evt_data_o  = evt_out_s.data;
      evt_src_x_o = evt_out_s.x;
      evt_src_y_o = evt_out_s.y;
    end else begin
      evt_type_o  = 3'd0;
    end
  end

  assign finish_set_s = evt_enq_s & (evt_type_s == HOST_EVT_FINISH);
  assign fail_set_s   = evt_enq_s & (evt_type_s == HOST_EVT_FAIL);
  assign error_set_s  = accept_s & (unmapped_s | req_op_i[1]);

  // Saturating finish counter next value.
  always_comb begin
    finish_cnt_next_s = finish_cnt_r;
    if (finish_set_s && (finish_cnt_r != fc_target_lp)) begin
      finish_cnt_next_s = finish_cnt_r + fc_width_lp'(1);
    end else begin
      finish_cnt_next_s = finish_cnt_r;
    end
  end

  // Status registers; done rises with the count update and all flags are sticky.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      finish_cnt_r <= '0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      finish_cnt_r <= finish_cnt_next_s;
      done_r       <= done_r | (finish_cnt_next_s == fc_target_lp);
      fail_r       <= fail_r | fail_set_s;
      error_r      <= error_r | error_set_s;
    end
  end

  assign done_o  = done_r;
  assign fail_o  = fail_r;
  assign error_o = error_r;

endmodule
